// File: rtl/mult_unit_if.sv
// Issue/completion bundle between the EX stage, the multiplier and the
// forwarding unit. HI/LO and the completion tag come back on the same bundle.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [4:0]       rd;
  logic             flush;
  logic             busy;
  logic             mult_ready;
  logic [4:0]       mult_rd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, rs_data, rt_data, rd, flush,
    input  busy, mult_ready, mult_rd, hi, lo
  );

  modport slave (
    input  start, is_signed, rs_data, rt_data, rd, flush,
    output busy, mult_ready, mult_rd, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative MULT/MULTU unit owning HI/LO: one 8-bit multiplier slice per
// cycle, fixed 4-cycle latency, sign restored on write-back.
module mult_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic      i_clk,
  input  logic      i_rst,
  mult_unit_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] mcand, mplier;
  logic             neg;
  logic [4:0]       rd_q, mult_rd_q;
  logic [PW-1:0]    acc, partial, sum;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             ready_q;
  logic [STEP-1:0]  slice;
  logic [31:0]      shamt;
  logic             accept, finish;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic take);
    // 0x8000_0000 maps to 2^31, which still fits as an unsigned value
    return (take && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic n);
    return n ? (~v + PW'(1)) : v;
  endfunction

  always_comb begin
    shamt   = 32'(cnt) * 32'(STEP);
    slice   = STEP'(mplier >> shamt);
    partial = ({{WIDTH{1'b0}}, mcand} * {{(PW-STEP){1'b0}}, slice}) << shamt;
    sum     = acc + partial;
    accept  = (state == IDLE) && bus.start && !bus.flush;
    finish  = (state == RUN) && (cnt == 2'd3) && !bus.flush;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (bus.flush || cnt == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
      rd_q      <= '0;
      mult_rd_q <= '0;
      acc       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (accept) begin
        mcand  <= magnitude(bus.rs_data, bus.is_signed);
        mplier <= magnitude(bus.rt_data, bus.is_signed);
        neg    <= bus.is_signed & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
        rd_q   <= bus.rd;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc <= sum;
        cnt <= cnt + 2'd1;
        // Completion edge: a flush here suppresses both the write and the pulse
        if (finish) begin
          {hi_q, lo_q} <= apply_sign(sum, neg);
          ready_q      <= 1'b1;
          mult_rd_q    <= rd_q;
        end
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.mult_ready = ready_q;
  assign bus.mult_rd    = mult_rd_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: a reference product is queued at issue and
// compared against HI/LO/rd when the completion pulse appears.
module tb_mult_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mult_unit_if #(.WIDTH(32)) bus ();

  mult_unit #(.WIDTH(32), .STEP(8)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents the op for exactly one rising edge.
  task automatic issue(input logic [31:0] rs, input logic [31:0] rt,
                       input logic sgn, input logic [4:0] rd, input bit push);
    logic signed [63:0] p;
    exp_t e;
    if (sgn) p = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    else     p = $signed({32'b0, rs} * {32'b0, rt});
    e.hi = p[63:32];
    e.lo = p[31:0];
    e.rd = rd;
    if (push) exp_q.push_back(e);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.rs_data   = rs;
    bus.rt_data   = rt;
    bus.rd        = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Returns at the negedge of the pulse cycle.
  task automatic expect_done(input string tag);
    int   busy_cnt = 0;
    int   cycles   = 0;
    bit   seen     = 0;
    exp_t e;
    while (cycles < 12 && !seen) begin
      @(negedge clk);
      cycles++;
      if (bus.mult_ready) seen = 1;
      else if (bus.busy) busy_cnt++;
    end
    check({tag, ".ready_seen"}, 64'(seen), 64'd1);
    check({tag, ".latency"}, 64'(cycles), 64'd5);
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd4);
    if (exp_q.size() == 0) begin
      check({tag, ".queue_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".hi"}, 64'(bus.hi), 64'(e.hi));
      check({tag, ".lo"}, 64'(bus.lo), 64'(e.lo));
      check({tag, ".rd"}, 64'(bus.mult_rd), 64'(e.rd));
    end
  endtask

  task automatic expect_quiet(input string tag, input int n,
                              input logic [31:0] hi, input logic [31:0] lo);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.mult_ready) pulses++;
    end
    check({tag, ".no_pulse"}, 64'(pulses), 64'd0);
    check({tag, ".hi"}, 64'(bus.hi), 64'(hi));
    check({tag, ".lo"}, 64'(bus.lo), 64'(lo));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.rs_data   = '0;
    bus.rt_data   = '0;
    bus.rd        = '0;
    bus.flush     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.ready", 64'(bus.mult_ready), 64'd0);
    check("reset.hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset.rd", 64'(bus.mult_rd), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd9, 1);
    expect_done("multu_max");
    check("multu_max.const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    check("multu_max.pulse_one_cycle", 64'(bus.mult_ready), 64'd0);
    check("multu_max.rd_hold", 64'(bus.mult_rd), 64'd9);

    issue(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 5'd1, 1);
    expect_done("mult_neg3x7");
    check("mult_neg3x7.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);

    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 5'd2, 1);
    expect_done("mult_min");
    check("mult_min.const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    @(negedge clk);

    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 5'd2, 1);
    expect_done("multu_min");
    check("multu_min.const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    @(negedge clk);

    issue(32'h1234_5678, 32'h8765_4321, 1'b1, 5'd17, 1);
    expect_done("mult_mixed");
    @(negedge clk);

    issue(32'd0, 32'hDEAD_BEEF, 1'b0, 5'd30, 1);
    expect_done("multu_zero");
    @(negedge clk);

    // Back-to-back: second issue lands in the pulse cycle of the first
    issue(32'd6, 32'd7, 1'b0, 5'd3, 1);
    expect_done("b2b_first");
    check("b2b_first.const", {bus.hi, bus.lo}, 64'd42);
    issue(32'h0001_0000, 32'h0001_0000, 1'b0, 5'd4, 1);
    expect_done("b2b_second");
    check("b2b_second.const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    @(negedge clk);

    issue(32'd2, 32'h8000_0001, 1'b0, 5'd5, 1);
    expect_done("preload");
    check("preload.const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0002);
    @(negedge clk);

    // Flush in the third RUN cycle
    issue(32'd5, 32'd5, 1'b0, 5'd6, 0);
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_run.busy", 64'(bus.busy), 64'd0);
    expect_quiet("flush_run", 8, 32'h1, 32'h2);

    // Flush on the completion edge
    issue(32'd5, 32'd5, 1'b0, 5'd7, 0);
    repeat (4) @(negedge clk);
    check("flush_e4.busy_before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    expect_quiet("flush_e4", 6, 32'h1, 32'h2);
    check("flush_e4.rd_hold", 64'(bus.mult_rd), 64'd5);

    // Flush together with start in IDLE
    bus.flush = 1'b1;
    issue(32'd5, 32'd5, 1'b0, 5'd8, 0);
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_start.busy", 64'(bus.busy), 64'd0);
    expect_quiet("flush_start", 6, 32'h1, 32'h2);

    // Asynchronous reset mid-operation
    issue(32'd9, 32'd9, 1'b0, 5'd10, 0);
    repeat (2) @(negedge clk);
    check("rst_mid.busy_before", 64'(bus.busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid.busy", 64'(bus.busy), 64'd0);
    check("rst_mid.hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_mid.rd", 64'(bus.mult_rd), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("rst_mid", 8, 32'h0, 32'h0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
